ysyx_22050612_core_sequencer: RTL

//  Multi-cycle control FSM for the core datapath. Sequences each instruction through

---
 rtl/ysyx_22050612_core_sequencer_if.sv | 27 ++
 rtl/ysyx_22050612_core_sequencer.sv | 109 ++++++++++
 2 files changed

// File: rtl/ysyx_22050612_core_sequencer_if.sv
// Handshake bundle between the core sequencer and its memory ports and decode unit.
// Build option: none; the sequencer's counters depend on YSYX_22050612_PERF_CNT_EN.
// master: sequencer side. It drives the requests and enables, and receives the grants, acks and decode class flags.
// slave:  memory/decode side. It has the opposite directions.
interface ysyx_22050612_core_sequencer_if;
    logic imem_req;
    logic imem_gnt;
    logic ir_we;
    logic dec_load;
    logic dec_store;
    logic dec_halt;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ack;
    logic rf_we;
    logic pc_we;

    modport master (
        output imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we,
        input  imem_gnt, dec_load, dec_store, dec_halt, dmem_ack
    );

    modport slave (
        input  imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we,
        output imem_gnt, dec_load, dec_store, dec_halt, dmem_ack
    );
endinterface

// File: rtl/ysyx_22050612_core_sequencer.sv
// Multi-cycle control FSM for the core.
// Each instruction goes through FETCH, DECODE, EXEC, optionally MEM, and then WB.
// The FSM stops in HALT when it decodes ebreak/halt.
// Ports:
//   clk, rst_n : core clock and asynchronous active-low reset
//   start      : level input that leaves IDLE; it is sampled only in IDLE
//   bus        : imem/dmem handshakes, IR/RF/PC write enables and decode class flags
//   halted     : core stopped
//   state      : current FSM state (debug)
//   cyc_cnt    : active-cycle counter
//   instret    : retired-instruction counter
// Build option: YSYX_22050612_PERF_CNT_EN enables the counters.
// When it is undefined, both counters read 0.
module ysyx_22050612_core_sequencer #(
    parameter int unsigned AUTO_START = 0,
    parameter int unsigned CNT_W      = 64
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    ysyx_22050612_core_sequencer_if.master       bus,
    output logic                                 halted,
    output logic [2:0]                           state,
    output logic [CNT_W-1:0]                     cyc_cnt,
    output logic [CNT_W-1:0]                     instret
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t state_q;
    state_t state_d;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state and control decode.
    // The controls are decoded from the state, so they drop as soon as reset is asserted.
    always_comb begin
        state_d      = state_q;
        bus.imem_req = 1'b0;
        bus.ir_we    = 1'b0;
        bus.dmem_req = 1'b0;
        bus.dmem_we  = 1'b0;
        bus.rf_we    = 1'b0;
        bus.pc_we    = 1'b0;
        halted       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start || (AUTO_START != 0)) state_d = S_FETCH;
            end
            S_FETCH: begin
                bus.imem_req = 1'b1;
                bus.ir_we    = bus.imem_gnt;
                if (bus.imem_gnt) state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = bus.dec_halt ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                state_d = (bus.dec_load || bus.dec_store) ? S_MEM : S_WB;
            end
            S_MEM: begin
                // A load with the store flag also set is treated as a store.
                bus.dmem_req = 1'b1;
                bus.dmem_we  = bus.dec_store;
                if (bus.dmem_ack) state_d = S_WB;
            end
            S_WB: begin
                bus.pc_we = 1'b1;
                bus.rf_we = ~bus.dec_store;
                state_d   = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign state = state_q;

`ifdef YSYX_22050612_PERF_CNT_EN
    // Performance counters. They wrap modulo 2^CNT_W and stay frozen in IDLE and HALT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt <= '0;
            instret <= '0;
        end else begin
            if (state_q != S_IDLE && state_q != S_HALT) cyc_cnt <= cyc_cnt + CNT_W'(1);
            if (state_q == S_WB)                        instret <= instret + CNT_W'(1);
        end
    end
`else
    assign cyc_cnt = '0;
    assign instret = '0;
`endif

endmodule
